// File: rtl/serializer_tx_pkg.sv
// Shared types and constants for the serial line transmitter.
// Also holds the counter-width helpers used by the top level and the bit timer.
package serializer_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serializer_tx_if.sv
// Word-input valid/ready handshake into the serial transmitter.
// The master drives a word; the slave accepts it.
interface serializer_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/serializer_tx_bit_timer.sv
// Oversampling phase counter: counts 0..OSR-1 while enabled.
// Flags the last phase of each serial bit.
module tx_bit_timer
  import serializer_tx_pkg::*;
#(
  parameter int OSR = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int              PH_W    = cnt_w(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  // Held at zero while disabled, so each frame starts on a fresh bit.
  always_comb begin
    bit_end_o = en_i && (phase_q == PH_LAST);
    phase_d   = '0;
    if (en_i && !bit_end_o) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial line transmitter: start bit, DATA_W data bits LSB first,
// STOP_BITS stop bits, each bit held for OSR clock cycles.
module serializer_tx
  import serializer_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OSR       = 4,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  serializer_tx_if.slave  in_if,
  output logic            out_data_o,
  output logic            busy_o
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  localparam int              BC_W         = cnt_w(max2(DATA_W, STOP_BITS));
  localparam logic [BC_W-1:0] BC_DATA_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BC_STOP_LAST = BC_W'(STOP_BITS - 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic              hold_full_d;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [DATA_W-1:0] shreg_shift;
  logic [BC_W-1:0]   bcnt_q;
  logic [BC_W-1:0]   bcnt_d;
  logic              out_q;
  logic              out_d;
  logic              busy_q;
  logic              busy_d;

  logic accept;
  logic load;
  logic bit_end;
  logic timer_en;

  assign in_if.in_ready = !hold_full_q;
  assign accept         = in_if.in_valid && !hold_full_q;
  assign timer_en       = (state_q != ST_IDLE);
  assign shreg_shift    = shreg_q >> 1;
  assign out_data_o     = out_q;
  assign busy_o         = busy_q;

  tx_bit_timer #(
    .OSR (OSR)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (timer_en),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_START;
          out_d   = ~IDLE_LEVEL;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bcnt_d  = '0;
          out_d   = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bcnt_q == BC_DATA_LAST) begin
            state_d = ST_STOP;
            bcnt_d  = '0;
            out_d   = IDLE_LEVEL;
          end else begin
            shreg_d = shreg_shift;
            bcnt_d  = bcnt_q + 1'b1;
            out_d   = shreg_shift[0];
          end
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bcnt_q == BC_STOP_LAST) begin
            // A waiting word starts right after the last stop bit, no idle gap.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = ST_START;
              out_d   = ~IDLE_LEVEL;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              out_d   = IDLE_LEVEL;
              busy_d  = 1'b0;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      shreg_d = hold_q;
    end
  end

  // Load and accept are exclusive: in_ready is low whenever hold is full.
  always_comb begin
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      bcnt_q      <= '0;
      out_q       <= IDLE_LEVEL;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bcnt_q      <= bcnt_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  // Data registers carry no reset; their contents are ignored until loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= in_if.in_data;
    end
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: table-driven isolated frames plus
// hand-written back-to-back, backpressure, reset and OSR=1 sequences.
module tb_serializer_tx;

  logic clk;
  logic rst_n;
  logic out0, busy0;
  logic out1, busy1;

  int n_vec = 0;
  int n_err = 0;

  serializer_tx_if #(.DATA_W(8)) if0 ();
  serializer_tx_if #(.DATA_W(4)) if1 ();

  serializer_tx #(.DATA_W(8), .OSR(4), .STOP_BITS(1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if0.slave),
    .out_data_o (out0),
    .busy_o     (busy0)
  );

  serializer_tx #(.DATA_W(4), .OSR(1), .STOP_BITS(2)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if1.slave),
    .out_data_o (out1),
    .busy_o     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Frame bit i is the line level during serial bit i: start, data LSB first, stop.
  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;
  } vec8_t;

  typedef struct {
    logic [3:0] word;
    logic [6:0] frame;
  } vec4_t;

  vec8_t tbl8[5];
  vec4_t tbl4[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle0(input string tag, input logic exp_rdy);
    chk({tag, " out"},   {31'd0, out0},          32'd1);
    chk({tag, " busy"},  {31'd0, busy0},         32'd0);
    chk({tag, " ready"}, {31'd0, if0.in_ready},  {31'd0, exp_rdy});
  endtask

  task automatic check_cycle0(input logic [9:0] f, input int c, input logic exp_rdy, input string tag);
    string nm;
    logic  exp_bit;
    nm      = $sformatf("%s c%0d", tag, c);
    exp_bit = f[c / 4];
    chk({nm, " out"},   {31'd0, out0},         {31'd0, exp_bit});
    chk({nm, " busy"},  {31'd0, busy0},        32'd1);
    chk({nm, " ready"}, {31'd0, if0.in_ready}, {31'd0, exp_rdy});
  endtask

  task automatic check_frame0(input logic [9:0] f, input int from, input int to,
                              input logic exp_rdy, input string tag);
    for (int c = from; c <= to; c++) begin
      @(negedge clk);
      check_cycle0(f, c, exp_rdy, tag);
    end
  endtask

  initial begin
    tbl8[0] = '{word: 8'hA5, frame: 10'b1_10100101_0};
    tbl8[1] = '{word: 8'h00, frame: 10'b1_00000000_0};
    tbl8[2] = '{word: 8'hFF, frame: 10'b1_11111111_0};
    tbl8[3] = '{word: 8'h3C, frame: 10'b1_00111100_0};
    tbl8[4] = '{word: 8'h81, frame: 10'b1_10000001_0};
    tbl4[0] = '{word: 4'h6, frame: 7'b11_0110_0};
    tbl4[1] = '{word: 4'h9, frame: 7'b11_1001_0};

    rst_n        = 1'b0;
    if0.in_valid = 1'b0;
    if0.in_data  = '0;
    if1.in_valid = 1'b0;
    if1.in_data  = '0;

    // Reset state, then ten quiet cycles.
    repeat (3) @(negedge clk);
    check_idle0("reset", 1'b1);
    chk("reset1 out", {31'd0, out1}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle0($sformatf("quiet%0d", i), 1'b1);
    end

    // Isolated frames from the table.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec %02h", tbl8[v].word);
      @(negedge clk);
      if0.in_data  = tbl8[v].word;
      if0.in_valid = 1'b1;
      chk({tag, " accept ready"}, {31'd0, if0.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if0.in_valid = 1'b0;
      if0.in_data  = ~tbl8[v].word;
      @(negedge clk);
      check_idle0({tag, " preload"}, 1'b0);
      check_frame0(tbl8[v].frame, 0, 39, 1'b1, tag);
      @(negedge clk);
      check_idle0({tag, " after"}, 1'b1);
    end

    // Back-to-back: valid held high across 0x00, 0xFF, 0x3C.
    @(negedge clk);
    if0.in_data  = 8'h00;
    if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_data = 8'hFF;
    @(negedge clk);
    check_idle0("b2b preload", 1'b0);
    @(negedge clk);
    check_cycle0(tbl8[1].frame, 0, 1'b1, "b2b 00");
    @(posedge clk);
    #1;
    if0.in_data = 8'h3C;
    check_frame0(tbl8[1].frame, 1, 39, 1'b0, "b2b 00");
    @(negedge clk);
    check_cycle0(tbl8[2].frame, 0, 1'b1, "b2b ff");
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check_frame0(tbl8[2].frame, 1, 39, 1'b0, "b2b ff");
    check_frame0(tbl8[3].frame, 0, 39, 1'b1, "b2b 3c");
    @(negedge clk);
    check_idle0("b2b after", 1'b1);

    // Backpressure: 0x11 waits in hold during 0x55, 0x22 waits for 0x11 to start.
    @(negedge clk);
    if0.in_data  = 8'h55;
    if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    @(negedge clk);
    check_idle0("bp preload", 1'b0);
    check_frame0(10'b1_01010101_0, 0, 4, 1'b1, "bp 55");
    if0.in_data  = 8'h11;
    if0.in_valid = 1'b1;
    chk("bp 11 ready", {31'd0, if0.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if0.in_data = 8'h22;
    check_frame0(10'b1_01010101_0, 5, 39, 1'b0, "bp 55");
    @(negedge clk);
    check_cycle0(10'b1_00010001_0, 0, 1'b1, "bp 11");
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check_frame0(10'b1_00010001_0, 1, 39, 1'b0, "bp 11");
    check_frame0(10'b1_00100010_0, 0, 39, 1'b1, "bp 22");
    @(negedge clk);
    check_idle0("bp after", 1'b1);

    // Reset mid-DATA of 0xF0 while 0x0F is held.
    @(negedge clk);
    if0.in_data  = 8'hF0;
    if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    @(negedge clk);
    check_frame0(10'b1_11110000_0, 0, 5, 1'b1, "rst f0");
    if0.in_data  = 8'h0F;
    if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check_frame0(10'b1_11110000_0, 6, 9, 1'b0, "rst f0");
    rst_n = 1'b0;
    #1;
    check_idle0("rst async", 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle0($sformatf("rst quiet%0d", i), 1'b1);
    end

    // OSR=1, DATA_W=4, STOP_BITS=2 instance.
    for (int v = 0; v < 2; v++) begin
      string tag;
      logic  exp_bit;
      tag = $sformatf("osr1 %0h", tbl4[v].word);
      @(negedge clk);
      if1.in_data  = tbl4[v].word;
      if1.in_valid = 1'b1;
      chk({tag, " ready"}, {31'd0, if1.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if1.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, " preload out"}, {31'd0, out1}, 32'd1);
      chk({tag, " preload busy"}, {31'd0, busy1}, 32'd0);
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        exp_bit = tbl4[v].frame[c];
        chk($sformatf("%s c%0d out", tag, c), {31'd0, out1}, {31'd0, exp_bit});
        chk($sformatf("%s c%0d busy", tag, c), {31'd0, busy1}, 32'd1);
      end
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk($sformatf("%s idle%0d out", tag, i), {31'd0, out1}, 32'd1);
        chk($sformatf("%s idle%0d busy", tag, i), {31'd0, busy1}, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_tx.md
# serializer_tx

Parallel-to-serial line transmitter for the CDR data-recovery link. It accepts DATA_W-bit words over a valid/ready handshake and drives a single-ended serial line. Each word is framed with one start bit, the data bits LSB first, and STOP_BITS stop bits. Every bit is held for OSR clk cycles, so the far-end oversampling receiver sees a guaranteed transition at each frame start.

## Interface
- DATA_W, 8, word width in bits; ≥1
- OSR, 4, clk cycles per serial bit; ≥1
- STOP_BITS, 1, number of stop bits per frame; ≥1
- clk  input  1  clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a word to send
- in_ready  output  1  block can accept a word; equals !hold_full
- in_data  input  DATA_W  word to transmit
- out_data  output  1  serial line, registered; idle level 1
- busy  output  1  registered; high while a frame is on the line (START, DATA or STOP)

## Operation
- Storage:
  - One-entry holding register (hold, hold_full).
  - Shift register shreg (DATA_W).
  - Phase counter phase, counting 0..OSR-1, width $clog2(OSR) (min 1).
  - Bit counter bcnt, width $clog2(max(DATA_W, STOP_BITS)) (min 1).
- Accept: on posedge with in_valid && in_ready, set hold <= in_data and hold_full <= 1. in_ready is combinational !hold_full.
- FSM states:
  - IDLE: out_data=1, busy=0. If hold_full, go to START: shreg <= hold, hold_full <= 0, phase <= 0, out_data <= 0, busy <= 1.
  - START: out_data=0 for OSR cycles. At phase==OSR-1, go to DATA with bcnt <= 0 and out_data <= shreg[0].
  - DATA: out_data = current LSB. At phase==OSR-1:
    - if bcnt==DATA_W-1, go to STOP with bcnt <= 0 and out_data <= 1;
    - otherwise shreg >>= 1, bcnt++, and out_data <= next bit.
  - STOP: out_data=1. At phase==OSR-1:
    - if bcnt==STOP_BITS-1 and hold_full, go directly to START, loading hold as in IDLE (back-to-back, no idle gap);
    - if bcnt==STOP_BITS-1 and !hold_full, go to IDLE with busy <= 0;
    - otherwise bcnt++.
- phase increments every cycle outside IDLE and wraps to 0 on every bit boundary.
- Simultaneous accept and load cannot occur, because in_ready=0 whenever hold_full=1. A word accepted while a frame is in flight waits in hold.
- Reset values: out_data=1, busy=0, hold_full=0 (so in_ready=1), state=IDLE, phase=0, bcnt=0. shreg and hold are not reset.
- Reset asserted mid-frame: the line returns to 1 immediately (asynchronous). The in-flight word and any held word are discarded.
- in_data is sampled only on the accepting edge. There is no stability requirement afterwards.

## Timing
- Acceptance at edge k: out_data falls at edge k+1 if the FSM is IDLE. Latency is 1 cycle from acceptance to the line.
- Frame length: (1 + DATA_W + STOP_BITS) × OSR cycles. busy is high for exactly this many cycles per isolated frame.
- Back-to-back: the next start bit follows the last stop bit with zero idle cycles. busy stays high throughout.
- in_ready re-asserts the cycle after hold is loaded into shreg. Sustained throughput is one word per frame.
- OSR=1: the phase counter is degenerate (phase always 0). Every cycle is a bit boundary.

## Structure
- Package serializer_tx_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - the IDLE_LEVEL = 1'b1 constant.
- One natural sub-module: tx_bit_timer. It is parameterised by OSR, counts phase, and outputs bit_end (phase==OSR-1) while enabled. The top level holds the FSM, hold register, shreg and bcnt.

## Test plan
- Defaults; after reset release, no input for 10 cycles -> out_data=1, busy=0 and in_ready=1 on every cycle.
- Send 0xA5 -> out_data=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. busy is high for exactly 40 cycles; line low starts 1 cycle after acceptance.
- Hold in_valid with 0x00, then 0xFF, then 0x3C -> 120 contiguous frame cycles with no idle gap. Each decodes correctly. in_ready is low from the second acceptance until each load.
- Backpressure: present 0x11 and 0x22 while 0x55 is in flight -> 0x11 waits in hold with in_ready=0, and 0x22 is not accepted until 0x11 starts.
- Assert rst_n low mid-DATA of 0xF0 with 0x0F held -> out_data=1 immediately; after release, the line stays idle and neither word is sent.
- OSR=1, DATA_W=4, STOP_BITS=2; send 0x6 -> line 0, 0, 1, 1, 0, 1, 1 over 7 cycles, then idle.
